// File: rtl/apb_pkg.sv
// Shared definitions for the arbitrated APB master.
// Contents: APB address/data widths, default wait-state timeout, FSM state enum.
package apb_pkg;

    localparam int unsigned ApbAddrW       = 32;
    localparam int unsigned ApbDataW       = 32;
    localparam int unsigned DefaultTimeout = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the pointer,
// wrapping around; the grant is one-hot or all zero.
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [IdxW-1:0]  index of the highest-priority requester
//   gnt_o  [NREQ-1:0]  one-hot grant
module apb_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    int          idx;
    logic [IdxW-1:0] sel;
    logic        found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            sel = IdxW'(idx);
            if (!found && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NREQ requesters through a round-robin arbiter.
// A requester is accepted in IDLE (valid & ready), its command is latched, the
// APB SETUP/ACCESS phases run, and a one-cycle rsp_valid pulse returns to the owner.
// Ports:
//   PCLK, PRESETn                     clock, async active-low reset
//   req_valid/req_ready [NREQ]        request handshake (ready is one-hot)
//   req_write [NREQ], req_addr/req_wdata [NREQ*32]  packed requester commands
//   rsp_valid [NREQ], rsp_rdata [32], rsp_err       completion to owner
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA           APB master outputs
//   PRDATA, PREADY, PSLVERR                         APB slave responses
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ApbAddrW-1:0] req_addr,
    input  logic [NREQ*ApbDataW-1:0] req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [ApbDataW-1:0]      rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSELx,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ApbAddrW-1:0]      PADDR,
    output logic [ApbDataW-1:0]      PWDATA,
    input  logic [ApbDataW-1:0]      PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    apb_state_e            state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ApbAddrW-1:0]   addr_q, addr_d;
    logic [ApbDataW-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0]       wait_q, wait_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [ApbDataW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    // Holds off grants until the first clock after reset so req_ready is 0 in reset.
    logic                  en_q;

    logic [NREQ-1:0]       grant;
    logic [IdxW-1:0]       gnt_idx;
    logic                  accept;
    logic [ApbAddrW-1:0]   addr_arr  [NREQ];
    logic [ApbDataW-1:0]   wdata_arr [NREQ];

    apb_rr_arbiter #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (grant)
    );

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_arr[i]  = req_addr[i*ApbAddrW +: ApbAddrW];
            wdata_arr[i] = req_wdata[i*ApbDataW +: ApbDataW];
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                gnt_idx = IdxW'(i);
            end
        end
    end

    assign req_ready = (state_q == StIdle && en_q) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                wait_d = '0;
                if (accept) begin
                    state_d = StSetup;
                    owner_d = gnt_idx;
                    write_d = req_write[gnt_idx];
                    addr_d  = addr_arr[gnt_idx];
                    wdata_d = req_write[gnt_idx] ? wdata_arr[gnt_idx] : '0;
                    if (32'(gnt_idx) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                wait_d  = '0;
            end
            StAccess: begin
                if (PREADY) begin
                    state_d              = StIdle;
                    wait_d               = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = write_q ? '0 : PRDATA;
                    rsp_err_d            = PSLVERR;
                end else if (wait_q == CntW'(TIMEOUT - 1)) begin
                    // This ACCESS cycle is the TIMEOUT-th wait state.
                    state_d              = StIdle;
                    wait_d               = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            en_q        <= 1'b1;
        end
    end

    assign PSELx     = (state_q != StIdle);
    assign PENABLE   = (state_q == StAccess);
    assign PWRITE    = PSELx ? write_q : 1'b0;
    assign PADDR     = PSELx ? addr_q : '0;
    assign PWDATA    = PSELx ? wdata_q : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb (NREQ=2, TIMEOUT=16): a per-cycle vector
// table for arbitration and a simple read, plus hand-written write/wait-state,
// timeout and mid-transfer reset sequences.
module tb_apb_master_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    int n_vec = 0;
    int n_err = 0;

    apb_master_arb #(
        .NREQ    (2),
        .TIMEOUT (16)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
        logic [1:0]  e_ready;
        logic        e_psel;
        logic        e_pen;
        logic        e_pwrite;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [1:0]  e_rsp;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] bundle(logic [1:0] rdy, logic ps, logic pe, logic pw,
                                            logic [31:0] pa, logic [31:0] pd, logic [1:0] rv,
                                            logic [31:0] rd, logic er);
        return {24'd0, rdy, ps, pe, pw, pa, pd, rv, rd, er};
    endfunction

    function automatic logic [127:0] act_bundle();
        return bundle(req_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
                      rsp_err);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rdy, input logic [31:0] rd, input logic err);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        pready    = rdy;
        prdata    = rd;
        pslverr   = err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // Arbitration: requesters 0 and 1 both hold valid for 4 transfers.
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 1, 0, 0,
                         2'b00, 1, 0, 0, 32'h20, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 1, 32'h1111_0000, 0,
                         2'b00, 1, 1, 0, 32'h20, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b10, 0, 0, 0, 0, 0, 2'b01, 32'h1111_0000, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b00, 1, 0, 0, 32'h24, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 1, 32'h2222_0001, 0,
                         2'b00, 1, 1, 0, 32'h24, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b01, 0, 0, 0, 0, 0, 2'b10, 32'h2222_0001, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b00, 1, 0, 0, 32'h20, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 1, 32'h3333_0002, 0,
                         2'b00, 1, 1, 0, 32'h20, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b10, 0, 0, 0, 0, 0, 2'b01, 32'h3333_0002, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b00, 1, 0, 0, 32'h24, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b11, 2'b00, 32'h20, 32'h24, 0, 0, 1, 32'h4444_0003, 0,
                         2'b00, 1, 1, 0, 32'h24, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 2'b00, 32'h20, 32'h24, 0, 0, 0, 0, 0,
                         2'b00, 0, 0, 0, 0, 0, 2'b10, 32'h4444_0003, 0});
        // Single read by requester 0; address changed after acceptance must not leak.
        vecs.push_back('{2'b01, 2'b00, 32'h40, 0, 0, 0, 0, 0, 0,
                         2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 2'b00, 32'h99, 0, 0, 0, 0, 0, 0,
                         2'b00, 1, 0, 0, 32'h40, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 2'b00, 32'h99, 0, 0, 0, 1, 32'hDEAD_BEEF, 0,
                         2'b00, 1, 1, 0, 32'h40, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 2'b00, 32'h99, 0, 0, 0, 0, 0, 1,
                         2'b00, 0, 0, 0, 0, 0, 2'b01, 32'hDEAD_BEEF, 0});

        // Reset with requests pending: every output must be 0.
        drive(2'b11, 2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 1, 32'h5, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", act_bundle(), 128'd0);
        repeat (2) @(negedge clk);
        chk("reset_held", act_bundle(), 128'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].write, vecs[i].addr0, vecs[i].addr1,
                  vecs[i].wdata0, vecs[i].wdata1, vecs[i].pready, vecs[i].prdata,
                  vecs[i].pslverr);
            #1;
            chk($sformatf("vec%0d", i), act_bundle(),
                bundle(vecs[i].e_ready, vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_pwrite,
                       vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_rsp, vecs[i].e_rdata,
                       vecs[i].e_err));
        end

        // Write 0x55 to 0x100, three wait states, then PREADY with PSLVERR.
        @(negedge clk);
        drive(2'b01, 2'b01, 32'h100, 0, 32'h55, 0, 0, 0, 0);
        #1;
        chk("wr_accept", act_bundle(), bundle(2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(2'b00, 2'b00, 32'h0, 0, 32'hFF, 0, 0, 0, 1);
        #1;
        chk("wr_setup", act_bundle(), bundle(0, 1, 0, 1, 32'h100, 32'h55, 0, 0, 0));
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            #1;
            chk($sformatf("wr_wait%0d", w), act_bundle(),
                bundle(0, 1, 1, 1, 32'h100, 32'h55, 0, 0, 0));
        end
        @(negedge clk);
        pready  = 1'b1;
        prdata  = 32'h1234_5678;
        pslverr = 1'b1;
        #1;
        chk("wr_ready", act_bundle(), bundle(0, 1, 1, 1, 32'h100, 32'h55, 0, 0, 0));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wr_rsp", act_bundle(), bundle(0, 0, 0, 0, 0, 0, 2'b01, 0, 1));

        // Timeout: both valid, pointer favours requester 1; slave never ready.
        @(negedge clk);
        drive(2'b11, 2'b00, 32'h300, 32'h200, 0, 0, 0, 32'hBAD0_BAD0, 0);
        #1;
        chk("to_accept", act_bundle(), bundle(2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("to_setup", act_bundle(), bundle(0, 1, 0, 0, 32'h200, 0, 0, 0, 0));
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (!penable) break;
            cnt++;
        end
        chk("to_access_cycles", 128'(cnt), 128'd16);
        chk("to_rsp", act_bundle(), bundle(0, 0, 0, 0, 0, 0, 2'b10, 0, 1));

        // Reset during ACCESS of a requester-0 read (pointer would favour 1).
        @(negedge clk);
        drive(2'b01, 2'b00, 32'h500, 32'h600, 0, 0, 0, 0, 0);
        #1;
        chk("rst_accept", act_bundle(), bundle(2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        chk("rst_in_access", act_bundle(), bundle(0, 1, 1, 0, 32'h500, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        pready = 1'b1;
        #1;
        chk("rst_async", act_bundle(), 128'd0);
        @(negedge clk);
        #1;
        chk("rst_no_rsp", act_bundle(), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_next_grant", act_bundle(), bundle(2'b01, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter NREQ, default 2, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16, maximum ACCESS-phase cycles waiting for PREADY.
REQ-003 PCLK  in  1  single clock; reset is asynchronous and active-low.
REQ-004 PRESETn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  NREQ  per-requester transfer request.
REQ-006 req_ready  out  NREQ  one-hot grant; a request is accepted on a clock edge where valid&ready are both high.
REQ-007 req_write  in  NREQ  1=write, 0=read, per requester.
REQ-008 req_addr  in  NREQ*32  packed per-requester address.
REQ-009 req_wdata  in  NREQ*32  packed per-requester write data.
REQ-010 rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
REQ-011 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-012 rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid.
REQ-013 PSELx, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-014 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-015 PRDATA  in  32; PREADY, PSLVERR  in  1 each  APB slave responses.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; IDLE->SETUP on acceptance, SETUP->ACCESS unconditionally, ACCESS->IDLE on PREADY=1 or timeout.
REQ-017 req_ready is asserted only in IDLE, only to the round-robin winner among valid requesters, and never to more than one requester.
REQ-018 Round-robin priority starts at the requester after the last granted one; after reset requester 0 has highest priority.
REQ-019 On acceptance, write, address, write data and owner index are latched; later changes to requester inputs do not affect the transfer.
REQ-020 SETUP: PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched values.
REQ-021 ACCESS: PSELx=1, PENABLE=1, with address, control and data held stable until exit.
REQ-022 In IDLE, PSELx=0 and PENABLE=0; PWDATA is driven to 0 on reads.
REQ-023 When ACCESS sees PREADY=1, the next cycle pulses rsp_valid[owner] for 1 cycle, with rsp_rdata=PRDATA (reads; 0 on writes) and rsp_err=PSLVERR.
REQ-024 Minimum accept-to-rsp_valid latency is 3 cycles; the FSM spends at least one IDLE cycle between transfers.
REQ-025 A wait-state counter counts ACCESS cycles with PREADY=0; when it reaches TIMEOUT, the FSM leaves ACCESS and pulses rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-026 PSLVERR is sampled only in ACCESS when PREADY=1 and is ignored otherwise.
REQ-027 A requester keeping req_valid high after acceptance is treated as a new request; it becomes eligible again in the next IDLE.

Reset
REQ-028 Asserting PRESETn low, at any time including mid-transfer, immediately forces IDLE, all outputs 0, the round-robin pointer to requester 0, and the wait-state counter to 0.
REQ-029 A transfer aborted by reset produces no rsp_valid pulse.

Structure
REQ-030 Package apb_pkg holds the FSM state enum, the APB address and data width constants, and the default TIMEOUT value.
REQ-031 Round-robin selection is implemented in sub-module apb_rr_arbiter (request vector, pointer -> one-hot grant).

Verification
REQ-032 Single read by requester 0, slave PREADY=1 at ACCESS with PRDATA=0xDEADBEEF -> PSELx in cycles 1-2, PENABLE in cycle 2, rsp_valid[0] in cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-033 Requesters 0 and 1 hold valid continuously -> grants alternate 0,1,0,1 across 4 transfers.
REQ-034 Write to 0x100 with data 0x55, slave inserts 3 wait states and then PREADY with PSLVERR=1 -> PADDR, PWDATA and PWRITE stable throughout ACCESS; rsp_err=1.
REQ-035 Slave never asserts PREADY with TIMEOUT=16 -> exit after 16 ACCESS cycles; rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-036 PRESETn pulsed low during ACCESS -> all outputs 0 asynchronously, no rsp_valid, and the next grant goes to requester 0.
